// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: format decode feeding a registered
// valid/ready output stage backed by a one-entry skid register.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      instr,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal
);

   // Every format fits in 32 bits, and only the sign-extending formats can set
   // bit 31, so one signed widening covers S, U-on-RV64 and the zero-extended forms.
   function automatic logic [XLEN-1:0] decode_imm(input logic [31:7] ins,
                                                 input logic [2:0]  src);
      logic signed [31:0] v;
      v = '0;
      case (src)
         3'd0: v = {{20{ins[31]}}, ins[31:20]};
         3'd1: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         3'd2: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         3'd3: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         3'd4: v = {ins[31:12], 12'b0};
         3'd5: v = {27'b0, ins[19:15]};
         3'd6: v = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
         default: v = '0;
      endcase
      return XLEN'(v);
   endfunction

   logic [XLEN-1:0]  dec_imm;
   logic             dec_ill;
   logic             acc;

   logic             out_vld_q, out_vld_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_ill_q, out_ill_d;

   logic             skid_vld_q, skid_vld_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             skid_ill_q, skid_ill_d;

   assign dec_imm = decode_imm(instr, imm_src);
   assign dec_ill = (imm_src == 3'd7);
   assign acc     = in_valid & ~skid_vld_q;

   always_comb begin
      out_vld_d  = out_vld_q;
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_ill_d  = out_ill_q;
      skid_vld_d = skid_vld_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_ill_d = skid_ill_q;
      if (skid_vld_q) begin
         // in_ready is low whenever the skid holds data, so no input competes here
         if (out_ready) begin
            out_imm_d  = skid_imm_q;
            out_tag_d  = skid_tag_q;
            out_ill_d  = skid_ill_q;
            skid_vld_d = 1'b0;
         end
      end else if (acc) begin
         if (!out_vld_q || out_ready) begin
            out_vld_d = 1'b1;
            out_imm_d = dec_imm;
            out_tag_d = in_tag;
            out_ill_d = dec_ill;
         end else begin
            skid_vld_d = 1'b1;
            skid_imm_d = dec_imm;
            skid_tag_d = in_tag;
            skid_ill_d = dec_ill;
         end
      end else if (out_ready) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_imm_q  <= '0;
         out_tag_q  <= '0;
         out_ill_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_ill_q <= 1'b0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_imm_q  <= out_imm_d;
         out_tag_q  <= out_tag_d;
         out_ill_q  <= out_ill_d;
         skid_vld_q <= skid_vld_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_ill_q <= skid_ill_d;
      end
   end

   assign in_ready  = ~skid_vld_q;
   assign out_valid = out_vld_q;
   assign imm_ext   = out_imm_q;
   assign out_tag   = out_tag_q;
   assign illegal   = out_ill_q;

endmodule
